bus_client: RTL and testbench
=============================

# bus_client

Synthesisable bus client (slave) for the arbiter's client side: accepts a request on `rq`, inserts a programmable number of wait states, then completes the read or write against an internal register file with a one-cycle `ack` pulse. It replaces the behavioural client model for gate-level and FPGA runs and generalises it with configurable depth, latency and optional error reporting. It sits behind the bus arbiter grant path, one instance per client port.

## Interface
- `DATA_WIDTH`, 8: width of `dataW` / `dataR` and of each storage word
- `ADDR_WIDTH`, 4: width of `address`
- `DEPTH`, 16: implemented words, 1..2^ADDR_WIDTH; addresses >= DEPTH are out of range
- `WAIT_STATES`, 0: cycles inserted between request capture and `ack`, 0..15

Ports:
- `clk` input 1: clock, all state on rising edge
- `reset` input 1: asynchronous, active-high reset
- `address` input ADDR_WIDTH: word address
- `rq` input 1: request, level; held by master until `ack` seen
- `ack` output 1: acknowledge, one-cycle pulse per transaction
- `wr_ni` input 1: 1 = read, 0 = write
- `dataW` input DATA_WIDTH: write data
- `dataR` output DATA_WIDTH: read data, registered
- `err` output 1: out-of-range pulse, present only with `BUS_CLIENT_ERR_EN`

## Operation
- FSM states: IDLE, WAIT, ACK, RELEASE.
- IDLE: on `rq`=1 at an edge, latch `address`, `wr_ni`, `dataW`; go WAIT if WAIT_STATES>0 (load counter WAIT_STATES-1), else ACK.
- WAIT: counter decrements each cycle; at 0 go ACK. `rq`, `address`, `dataW` ignored while in WAIT (captured values used).
- ACK: `ack`=1 for exactly this cycle. Write (latched `wr_ni`=0, in range): word updated at the edge entering ACK. Read (in range): `dataR` loaded at the edge entering ACK with stored word. Out-of-range: write dropped, read loads `dataR`=0.
- Leaving ACK: if `rq`=1 go RELEASE, else IDLE.
- RELEASE: wait for `rq`=0, then IDLE. A request held high is served exactly once; new transaction needs `rq` low for at least one cycle.
- `rq` dropped during WAIT: transaction already committed; completes normally with `ack` pulse, then IDLE.
- `dataR` holds its value between reads; not changed by writes.

## Timing
- Reset (asynchronous): FSM IDLE, `ack`=0, `dataR`=0, `err`=0, all storage words 0, wait counter 0.
- Latency: `rq` sampled high at edge N -> `ack` high in the cycle following edge N+1+WAIT_STATES; `dataR` valid in that same cycle.
- WAIT_STATES=0: `ack` asserted the cycle after `rq` is sampled.
- Minimum spacing between two transactions: 3+WAIT_STATES cycles (capture, wait, ack, rq-low cycle).
- Reset asserted mid-transaction: transaction aborted, no write performed if reset precedes the ACK edge, outputs return to reset values immediately.
- All outputs registered; no combinational path from inputs to `ack`, `dataR`, `err`.

## Configuration
- `BUS_CLIENT_ERR_EN` defined: `err` port exists; `err`=1 in the ACK cycle iff latched address >= DEPTH, else 0; reset 0.
- Not defined: `err` port and its logic absent; out-of-range accesses still dropped/read as 0 silently.

## Test plan
- Reset then write 0xA5 to address 3, WAIT_STATES=0 -> `ack` single pulse one cycle after `rq` sampled; subsequent read of address 3 -> `dataR`=0xA5 in `ack` cycle.
- WAIT_STATES=3, read address 0 after reset -> `ack` rises exactly 4 cycles after `rq` sampled, `dataR`=0x00.
- `rq` held high 10 cycles after `ack` -> exactly one `ack`; second transaction only after `rq` low one cycle.
- DEPTH=12, write 0x3C to address 13 then read 13 -> `dataR`=0x00, storage unchanged; with `BUS_CLIENT_ERR_EN` `err`=1 in both ack cycles, 0 otherwise.
- Write 0xFF to address 5, assert `reset` during WAIT (WAIT_STATES=2) of a second write 0x11 to 5, release, read 5 -> `dataR`=0x00, no `ack` during reset.
- `rq` dropped one cycle into WAIT (WAIT_STATES=4) of write 0x42 to address 7 -> `ack` still pulses on schedule, read of 7 returns 0x42, FSM back to IDLE without RELEASE.

Source files
------------

// File: rtl/bus_client.sv
// Bus client (slave): captures a request, inserts WAIT_STATES wait cycles, then completes
// the read or write against a local register file with a one-cycle ack. Optional err port: BUS_CLIENT_ERR_EN.
module bus_client #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  rq,
  output logic                  ack,
  input  logic                  wr_ni,
  input  logic [DATA_WIDTH-1:0] dataW,
  output logic [DATA_WIDTH-1:0] dataR
`ifdef BUS_CLIENT_ERR_EN
  ,
  output logic                  err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_RELEASE
  } state_t;

  localparam int              WORDS   = 2 ** ADDR_WIDTH;
  localparam logic [3:0]      WS      = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state;
  state_t                  next_state;
  logic [3:0]              cnt;
  logic [3:0]              cnt_next;
  logic                    capture;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    in_range;
  logic [DATA_WIDTH-1:0]   mem [WORDS];

  assign in_range = ({1'b0, addr_q} < DEPTH_L);

  // The capture cycle is always spent in S_WAIT, so the counter is loaded with
  // WAIT_STATES (not WAIT_STATES-1) and ack lands WAIT_STATES+1 edges after capture.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rq) begin
          capture    = 1'b1;
          cnt_next   = WS;
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          commit     = 1'b1;
          next_state = S_ACK;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_ACK: begin
        next_state = rq ? S_RELEASE : S_IDLE;
      end
      S_RELEASE: begin
        if (!rq) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      wr_q   <= 1'b0;
      data_q <= '0;
      ack    <= 1'b0;
      dataR  <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      ack   <= commit;
      if (capture) begin
        addr_q <= address;
        wr_q   <= wr_ni;
        data_q <= dataW;
      end
      if (commit && wr_q) begin
        dataR <= in_range ? mem[addr_q] : '0;
      end
    end
  end

  // Words at or above DEPTH exist only to keep indexing simple; they are never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (commit && !wr_q && in_range) begin
      mem[addr_q] <= data_q;
    end
  end

`ifdef BUS_CLIENT_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= commit && !in_range;
    end
  end
`endif

endmodule

// File: tb/tb_bus_client.sv
// Self-checking bench for bus_client: scoreboard of expected read data / err per transaction,
// popped by a monitor on every ack, plus latency, single-pulse and reset-abort checks.
module tb_bus_client;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 12;
  localparam int WS    = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          rq;
  logic          ack;
  logic          wr_ni;
  logic [DW-1:0] dataW;
  logic [DW-1:0] dataR;
`ifdef BUS_CLIENT_ERR_EN
  logic          err;
`endif

  int            checks   = 0;
  int            failures = 0;
  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] model_mem [16];
  logic [DW-1:0] model_dataR;

  bus_client #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .address(address),
    .rq     (rq),
    .ack    (ack),
    .wr_ni  (wr_ni),
    .dataW  (dataW),
    .dataR  (dataR)
`ifdef BUS_CLIENT_ERR_EN
    ,
    .err    (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    model_dataR = '0;
    sb.delete();
  endtask

  // One transaction: push the expectation, raise rq, bound the wait for ack, check latency
  // and that ack is a single pulse. hold keeps rq high after ack; drop lowers it early.
  task automatic applyStimulus(input int a, input bit is_read, input logic [DW-1:0] d,
                               input int hold, input int drop);
    bit   in_rng;
    bit   got;
    int   cycles;
    int   extra;
    exp_t e;
    in_rng = (a < DEPTH);
    if (is_read) model_dataR = in_rng ? model_mem[a] : '0;
    else if (in_rng) model_mem[a] = d;
    e.data = model_dataR;
    e.err  = !in_rng;
    sb.push_back(e);
    @(negedge clk);
    address = AW'(a);
    wr_ni   = is_read;
    dataW   = d;
    rq      = 1'b1;
    cycles  = 0;
    got     = 1'b0;
    while (!got && cycles < WS + 10) begin
      @(negedge clk);
      cycles++;
      if (ack) got = 1'b1;
      else if (drop > 0 && cycles == drop) rq = 1'b0;
    end
    checkOutput("ack_latency", got ? cycles - 1 : -1, WS + 1);
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ack) extra++;
    end
    if (hold > 0) checkOutput("held_rq_acks", extra, 0);
    rq = 1'b0;
    @(negedge clk);
    checkOutput("ack_pulse", ack, 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ack) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_ack", ack, 0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("dataR", dataR, mon_e.data);
`ifdef BUS_CLIENT_ERR_EN
          checkOutput("err_ack", err, mon_e.err);
`endif
        end
      end
`ifdef BUS_CLIENT_ERR_EN
      else begin
        checkOutput("err_idle", err, 0);
      end
`endif
    end
  end

  initial begin
    reset   = 1'b1;
    rq      = 1'b0;
    address = '0;
    wr_ni   = 1'b1;
    dataW   = '0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_ack", ack, 0);
    checkOutput("reset_dataR", dataR, 0);
`ifdef BUS_CLIENT_ERR_EN
    checkOutput("reset_err", err, 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] basic write/read");
    applyStimulus(3, 1'b0, 8'hA5, 0, 0);
    applyStimulus(3, 1'b1, 8'h00, 0, 0);
    applyStimulus(0, 1'b1, 8'h00, 0, 0);

    $display("[TB] rq held after ack");
    applyStimulus(9, 1'b0, 8'h5A, 10, 0);
    applyStimulus(9, 1'b1, 8'h00, 0, 0);

    $display("[TB] out-of-range and boundary addresses");
    applyStimulus(13, 1'b0, 8'h3C, 0, 0);
    applyStimulus(13, 1'b1, 8'h00, 0, 0);
    applyStimulus(11, 1'b0, 8'h77, 0, 0);
    applyStimulus(12, 1'b0, 8'h99, 0, 0);
    applyStimulus(11, 1'b1, 8'h00, 0, 0);
    applyStimulus(12, 1'b1, 8'h00, 0, 0);
    applyStimulus(3, 1'b1, 8'h00, 0, 0);

    $display("[TB] reset during wait");
    applyStimulus(5, 1'b0, 8'hFF, 0, 0);
    applyStimulus(5, 1'b1, 8'h00, 0, 0);
    @(negedge clk);
    address = 4'd5;
    wr_ni   = 1'b0;
    dataW   = 8'h11;
    rq      = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1 checkOutput("reset_async_dataR", dataR, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_no_ack", ack, 0);
    end
    rq = 1'b0;
    modelReset();
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(5, 1'b1, 8'h00, 0, 0);

    $display("[TB] rq dropped during wait");
    applyStimulus(7, 1'b0, 8'h42, 0, 1);
    applyStimulus(7, 1'b1, 8'h00, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), 0, 0);
    end

    @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
